// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA counters plus registered, blanked colour and aligned syncs; TEST_PATTERN_EN adds a colour-bar test_mode input
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       en,
`ifdef TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [9:0] hcounter,
  output logic [9:0] vcounter,
  output logic [3:0] r_out,
  output logic [3:0] g_out,
  output logic [3:0] b_out,
  output logic       hsync,
  output logic       vsync,
  output logic       video_active,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] r_h, r_v;
  logic [7:0] r_fc;
  logic       r_started;
  logic [3:0] r_r, r_g, r_b;
  logic       r_act, r_hs, r_vs;
  logic       w_hend, w_vend, w_vis, w_hs, w_vs;
  logic [3:0] w_r, w_g, w_b;

  assign w_hend = r_h == H_LAST;
  assign w_vend = r_v == V_LAST;
  assign w_vis  = (r_h < H_VIS) && (r_v < V_VIS);
  assign w_hs   = (r_h >= HS_LO) && (r_h <= HS_HI);
  assign w_vs   = (r_v >= VS_LO) && (r_v <= VS_HI);

`ifdef TEST_PATTERN_EN
  logic [2:0] w_bar;
  assign w_bar = 3'(r_h / 10'(H_VISIBLE / 8));
  assign w_r   = test_mode ? {4{w_bar[2]}} : r_in;
  assign w_g   = test_mode ? {4{w_bar[1]}} : g_in;
  assign w_b   = test_mode ? {4{w_bar[0]}} : b_in;
`else
  assign w_r = r_in;
  assign w_g = g_in;
  assign w_b = b_in;
`endif

  // Stage 0: raster counters and completed-frame count; r_started keeps the
  // post-reset (0,0) from looking like a frame boundary
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      r_h       <= '0;
      r_v       <= '0;
      r_fc      <= '0;
      r_started <= 1'b0;
    end else if (en) begin
      r_started <= 1'b1;
      r_h       <= w_hend ? '0 : r_h + 10'd1;
      if (w_hend) r_v <= w_vend ? '0 : r_v + 10'd1;
      if (w_hend && w_vend) r_fc <= r_fc + 8'd1;
    end
  end

  // Stage 1: colour, blanking and syncs all registered from the same counter position
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      r_r   <= '0;
      r_g   <= '0;
      r_b   <= '0;
      r_act <= 1'b0;
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
    end else if (en) begin
      r_r   <= w_vis ? w_r : 4'd0;
      r_g   <= w_vis ? w_g : 4'd0;
      r_b   <= w_vis ? w_b : 4'd0;
      r_act <= w_vis;
      r_hs  <= w_hs ? SYNC_POL : ~SYNC_POL;
      r_vs  <= w_vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign hcounter     = r_h;
  assign vcounter     = r_v;
  assign frame_count  = r_fc;
  assign frame_start  = r_started && (r_h == '0) && (r_v == '0);
  assign r_out        = r_r;
  assign g_out        = r_g;
  assign b_out        = r_b;
  assign video_active = r_act;
  assign hsync        = r_hs;
  assign vsync        = r_vs;
endmodule
